// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU command path.
// Contents:
//   - opcode localparams (sel[3]=0 arithmetic group, sel[3]=1 logic group)
//   - command word width and field offsets for the {sel,a,b} command word
//   - operand/result widths
//   - FSM state encoding used by alu_op_sequencer
package alu_pkg;

  localparam int SEL_W  = 4;
  localparam int OPND_W = 4;
  localparam int RES_W  = 8;
  localparam int CMD_W  = 12;

  // Command word layout: {sel, a, b}
  localparam int CMD_B_LSB   = 0;
  localparam int CMD_A_LSB   = 4;
  localparam int CMD_SEL_LSB = 8;

  // Arithmetic group
  localparam logic [3:0] OP_INCA = 4'b0000;
  localparam logic [3:0] OP_INCB = 4'b0001;
  localparam logic [3:0] OP_DECA = 4'b0010;
  localparam logic [3:0] OP_DECB = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_NEGA = 4'b0111;
  // Logic group
  localparam logic [3:0] OP_NOTA = 4'b1000;
  localparam logic [3:0] OP_NOTB = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
  localparam logic [3:0] OP_OR   = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_XNOR = 4'b1110;
  localparam logic [3:0] OP_NOR  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH x CMD_W synchronous command FIFO.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  write request and command word; ignored while full
//   pop          read request; ignored while empty
//   rdata        head-of-queue command word (valid while !empty)
//   full, empty  occupancy flags, derived from registered pointers only
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] wdata,
  input  logic             pop,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [CMD_W-1:0] mem [DEPTH];

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rdata = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command stage in front of the 4-bit ALU.
// Buffers {sel,a,b} commands, issues one at a time on registered ALU operand
// lines, samples alu_y ALU_LATENCY edges after issue and returns it through a
// valid/ready result port.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (cmd_ready = !full)
//   cmd_sel, cmd_a, cmd_b            command fields
//   alu_a, alu_b, alu_sel            registered operands to the ALU
//   alu_y                            ALU result
//   res_valid/res_ready              result handshake
//   res_y, res_sel                   captured result and its opcode
//   ops_done                         count of accepted results (wraps)
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic        [SEL_W-1:0]  cmd_sel,
  input  logic signed [OPND_W-1:0] cmd_a,
  input  logic signed [OPND_W-1:0] cmd_b,
  output logic signed [OPND_W-1:0] alu_a,
  output logic signed [OPND_W-1:0] alu_b,
  output logic        [SEL_W-1:0]  alu_sel,
  input  logic signed [RES_W-1:0]  alu_y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [RES_W-1:0]  res_y,
  output logic        [SEL_W-1:0]  res_sel,
  output logic        [15:0]       ops_done
);

  localparam int WCNT_W = $clog2(ALU_LATENCY + 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic             issue;
  logic             capture;
  logic             accept;
  logic             full;
  logic             empty;
  logic [CMD_W-1:0] head;
  logic [CMD_W-1:0] cmd_word;

  assign cmd_word  = {cmd_sel, cmd_a, cmd_b};
  assign cmd_ready = !full;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (cmd_word),
    .pop   (issue),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Control decode: issue pops the FIFO and loads operands, capture samples
  // alu_y, accept completes the result handshake.
  always_comb begin
    issue   = 1'b0;
    capture = 1'b0;
    accept  = 1'b0;
    unique case (state)
      ST_IDLE: issue   = !empty;
      ST_WAIT: capture = (wcnt == WCNT_W'(1));
      ST_DONE: begin
        accept = res_ready;
        issue  = res_ready && !empty;
      end
      default: ;
    endcase
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (issue)   state_nxt = ST_WAIT;
      ST_WAIT: if (capture) state_nxt = ST_DONE;
      ST_DONE: if (accept)  state_nxt = issue ? ST_WAIT : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand registers change only on issue, so the ALU sees stable inputs
  // for the whole wait and while a result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      wcnt    <= '0;
    end else if (issue) begin
      alu_sel <= head[CMD_SEL_LSB +: SEL_W];
      alu_a   <= $signed(head[CMD_A_LSB +: OPND_W]);
      alu_b   <= $signed(head[CMD_B_LSB +: OPND_W]);
      wcnt    <= WCNT_W'(ALU_LATENCY);
    end else if (state == ST_WAIT) begin
      wcnt    <= wcnt - 1'b1;
    end
  end

  // Result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_sel   <= '0;
      ops_done  <= '0;
    end else begin
      if (capture) begin
        res_y     <= alu_y;
        res_sel   <= alu_sel;
        res_valid <= 1'b1;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
      if (accept) ops_done <= ops_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer paired with a behavioural 4-bit ALU that
// captures operands on the falling edge and registers y on the next rising
// edge. A queue-based scoreboard holds the expected results in command order.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic        [3:0]        cmd_sel;
  logic signed [3:0]        cmd_a;
  logic signed [3:0]        cmd_b;
  logic signed [3:0]        alu_a;
  logic signed [3:0]        alu_b;
  logic        [3:0]        alu_sel;
  logic signed [7:0]        alu_y = 8'sd0;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [7:0]        res_y;
  logic        [3:0]        res_sel;
  logic        [15:0]       ops_done;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_sel   (res_sel),
    .ops_done  (ops_done)
  );

  function automatic logic [7:0] alu_ref(input logic [3:0] sel,
                                         input logic signed [3:0] a,
                                         input logic signed [3:0] b);
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    logic signed [7:0] r;
    ea = a;
    eb = b;
    case (sel)
      OP_INCA: r = ea + 8'sd1;
      OP_INCB: r = eb + 8'sd1;
      OP_DECA: r = ea - 8'sd1;
      OP_DECB: r = eb - 8'sd1;
      OP_SUB:  r = ea - eb;
      OP_MUL:  r = ea * eb;
      OP_ADD:  r = ea + eb;
      OP_NEGA: r = -ea;
      OP_NOTA: r = ~ea;
      OP_NOTB: r = ~eb;
      OP_AND:  r = ea & eb;
      OP_OR:   r = ea | eb;
      OP_XOR:  r = ea ^ eb;
      OP_NAND: r = ~(ea & eb);
      OP_XNOR: r = ~(ea ^ eb);
      default: r = ~(ea | eb);
    endcase
    return r;
  endfunction

  // Behavioural ALU
  logic        [3:0] cap_sel = 4'd0;
  logic signed [3:0] cap_a   = 4'sd0;
  logic signed [3:0] cap_b   = 4'sd0;
  always @(negedge clk) begin
    cap_sel <= alu_sel;
    cap_a   <= alu_a;
    cap_b   <= alu_b;
  end
  always @(posedge clk) alu_y <= alu_ref(cap_sel, cap_a, cap_b);

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: observes handshakes half a cycle before the edge that
  // completes them.
  logic [7:0] exp_y_q[$];
  logic [3:0] exp_sel_q[$];
  int  model_ops = 0;
  int  cyc       = 0;
  int  last_hs   = -1;
  int  valid_cnt = 0;
  bit  spacing_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      exp_y_q.delete();
      exp_sel_q.delete();
      model_ops = 0;
    end else begin
      if (res_valid) valid_cnt++;
      if (cmd_valid && cmd_ready) begin
        exp_y_q.push_back(alu_ref(cmd_sel, cmd_a, cmd_b));
        exp_sel_q.push_back(cmd_sel);
      end
      if (res_valid && res_ready) begin
        if (exp_y_q.size() == 0) begin
          chk("spurious_result", 16'(exp_y_q.size()), 16'd1);
        end else begin
          chk("res_y", {8'h00, res_y}, {8'h00, exp_y_q.pop_front()});
          chk("res_sel", {12'h000, res_sel}, {12'h000, exp_sel_q.pop_front()});
          model_ops++;
          if (spacing_on && last_hs >= 0)
            chk("b2b_spacing", 16'(cyc - last_hs), 16'(LAT + 1));
          last_hs = cyc;
        end
      end
      if (!spacing_on) last_hs = -1;
    end
  end

  task automatic push(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    cmd_sel = s;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("push_timeout", {15'h0, acc}, 16'd1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("valid_timeout", {15'h0, res_valid}, 16'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_y_q.size() != 0 || res_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 16'(exp_y_q.size()), 16'd0);
  endtask

  initial begin
    int n;
    int vc;
    logic [15:0] base;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_sel = '0;
    cmd_a = '0;
    cmd_b = '0;
    res_ready = 1'b0;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", {15'h0, res_valid}, 16'd0);
    chk("rst_alu_sel", {12'h0, alu_sel}, 16'd0);
    chk("rst_ops_done", ops_done, 16'd0);
    chk("rst_res_y", {8'h0, res_y}, 16'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", {15'h0, cmd_ready}, 16'd1);

    // Add: result appears three edges after the push edge
    push(OP_ADD, 4'd3, 4'd2);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("add_latency", 16'(n), 16'd3);
    chk("add_y", {8'h0, res_y}, 16'h0005);
    chk("add_sel", {12'h0, res_sel}, 16'h0006);
    res_ready = 1'b1;
    wait_drain();

    // Multiply then complement, results in command order
    res_ready = 1'b0;
    push(OP_MUL, 4'b1101, 4'd4);
    push(OP_NOTA, 4'b0101, 4'($urandom));
    wait_valid();
    chk("mul_y", {8'h0, res_y}, 16'h00F4);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    wait_valid();
    chk("not_y", {8'h0, res_y}, 16'h00FA);
    res_ready = 1'b1;
    wait_drain();
    chk("ops_done_two", ops_done, 16'd3);

    // Fill the FIFO under backpressure
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(4'($urandom), 4'($urandom), 4'($urandom));
    chk("full_ready", {15'h0, cmd_ready}, 16'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {15'h0, res_valid}, 16'd1);
      chk("hold_y", {8'h0, res_y}, {8'h0, exp_y_q[0]});
      chk("hold_ready", {15'h0, cmd_ready}, 16'd0);
    end
    // Offer a command in the same cycle as the pop that frees a slot
    cmd_sel = OP_XOR;
    cmd_a = 4'sd5;
    cmd_b = -4'sd2;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_pop", {15'h0, cmd_ready}, 16'd1);
    push(OP_XOR, 4'd5, 4'b1110);
    wait_drain();
    chk("ops_done_full", ops_done, 16'(model_ops));

    // Back-to-back with res_ready held high
    base = ops_done;
    spacing_on = 1'b1;
    for (int i = 0; i < 8; i++) push(4'($urandom), 4'($urandom), 4'($urandom));
    wait_drain();
    spacing_on = 1'b0;
    chk("b2b_ops", ops_done - base, 16'd8);

    // Random traffic with random backpressure
    for (int i = 0; i < 200; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_sel = 4'($urandom);
      cmd_a = 4'($urandom);
      cmd_b = 4'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain();
    chk("rand_ops_done", ops_done, 16'(model_ops));

    // Reset during WAIT with two commands queued
    push(OP_ADD, 4'd1, 4'd1);
    push(OP_SUB, 4'd7, 4'd2);
    push(OP_OR, 4'd4, 4'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vc = valid_cnt;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_no_valid", 16'(valid_cnt - vc), 16'd0);
    chk("midrst_ops_done", ops_done, 16'd0);
    chk("midrst_cmd_ready", {15'h0, cmd_ready}, 16'd1);
    chk("midrst_alu_sel", {12'h0, alu_sel}, 16'd0);
    chk("midrst_res_y", {8'h0, res_y}, 16'd0);

    // Sequencer still works after the abandoned operation
    push(OP_ADD, 4'd3, 4'd2);
    wait_drain();
    chk("post_rst_ops", ops_done, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
